// File: rtl/wave_seq_pkg.sv
// wave_seq_pkg
// Shared definitions for the wave sequencer: FSM state encoding, default
// bus widths and the reset values of the step/range configuration.
package wave_seq_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 16;

  // Reset configuration: step of one, range covering the whole RAM
  // (every bit of the range register resets to RANGE_RST_FILL).
  localparam int   STEP_RST       = 1;
  localparam logic RANGE_RST_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2
  } wave_state_t;

endpackage

// File: rtl/wave_seq_addr_gen.sv
// wave_seq_addr_gen
// Combinational next-address and wrap computation for sample playback.
// The sum is formed one bit wider than the address so that addr + step
// cannot overflow before it is compared with the range.
//
// Ports:
//   addr       current playback address
//   step       address increment per sample
//   range      highest playable address (inclusive)
//   addr_next  address to use for the following read
//   wrap       high when addr + step passed the range
module wave_seq_addr_gen #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] step,
  input  logic [ADDR_WIDTH-1:0] range,
  output logic [ADDR_WIDTH-1:0] addr_next,
  output logic                  wrap
);

  logic [ADDR_WIDTH:0] sum;
  logic [ADDR_WIDTH:0] span;
  logic [ADDR_WIDTH:0] folded;
  logic [ADDR_WIDTH:0] limit;

  always_comb begin
    limit     = {1'b0, range};
    sum       = {1'b0, addr} + {1'b0, step};
    span      = limit + (ADDR_WIDTH+1)'(1);
    folded    = sum - span;
    addr_next = sum[ADDR_WIDTH-1:0];
    wrap      = 1'b0;
    if (sum > limit) begin
      wrap = 1'b1;
      // A step larger than the whole range can still land outside it after
      // one fold; clamp to the start of the table instead of folding again.
      if (folded > limit) begin
        addr_next = '0;
      end else begin
        addr_next = folded[ADDR_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer
// Sample RAM playback controller. Each accepted tick issues one RAM read at
// the current playback address, advances the address by the active step
// (wrapping within the active range) and returns the fetched sample with a
// one-cycle valid strobe.
//
// Optional build macro: WAVE_SEQ_ONESHOT_EN adds the 'oneshot' input, which
// stops playback after the fetch that wrapped until run is toggled.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   run            playback enable (level)
//   tick           one-cycle sample request
//   mem_lock       RAM is being written; no read may be issued
//   oneshot        (WAVE_SEQ_ONESHOT_EN only) stop after one pass
//   cfg_load       capture cfg_step/cfg_range into the shadow registers
//   cfg_step       address increment per sample
//   cfg_range      highest playable address (inclusive)
//   rd_en, rd_addr RAM read strobe and address (registered)
//   rd_data        RAM data, valid the cycle after rd_en
//   sample_out     last fetched sample (held)
//   sample_valid   one-cycle pulse with a new sample_out
//   wrap           one-cycle pulse alongside the read that wrapped
//   overrun        sticky: a tick arrived while a fetch was still pending
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; address held at 0, ticks ignored, config applies
// ST_WAIT  | armed; waiting for a tick (or a tick held back by mem_lock)
// ST_FETCH | read issued (rd_en cycle), then data capture cycle
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  tick,
  input  logic                  mem_lock,
`ifdef WAVE_SEQ_ONESHOT_EN
  input  logic                  oneshot,
`endif
  input  logic                  cfg_load,
  input  logic [ADDR_WIDTH-1:0] cfg_step,
  input  logic [ADDR_WIDTH-1:0] cfg_range,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  wrap,
  output logic                  overrun
);

  wave_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH-1:0] step_act, range_act;
  logic [ADDR_WIDTH-1:0] step_shd, range_shd;
  logic                  addr_wrap;
  logic                  pending;
  logic                  issue;
  logic                  capture;
  logic                  stop_now;
  logic                  arm_ok;
  logic                  cfg_apply;

`ifdef WAVE_SEQ_ONESHOT_EN
  logic wrap_seen;
  logic oneshot_done;

  assign stop_now = oneshot & wrap_seen;
  assign arm_ok   = ~oneshot_done;
`else
  assign stop_now = 1'b0;
  assign arm_ok   = 1'b1;
`endif

  wave_seq_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr     (addr),
    .step     (step_act),
    .range    (range_act),
    .addr_next(addr_nxt),
    .wrap     (addr_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Inside ST_FETCH the registered rd_en marks the first (read) cycle, so
  // rd_en low means this is the data capture cycle.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run && arm_ok) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if ((tick || pending) && !mem_lock) begin
          issue     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!rd_en) begin
          capture = 1'b1;
          if (!run || stop_now) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Active settings follow the shadow freely while stopped, otherwise only
  // at a wrap so a pass through the table is never mixed.
  assign cfg_apply = (state == ST_IDLE) || (issue && addr_wrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
      overrun      <= 1'b0;
      addr         <= '0;
      pending      <= 1'b0;
      step_act     <= ADDR_WIDTH'(STEP_RST);
      range_act    <= {ADDR_WIDTH{RANGE_RST_FILL}};
      step_shd     <= ADDR_WIDTH'(STEP_RST);
      range_shd    <= {ADDR_WIDTH{RANGE_RST_FILL}};
    end else begin
      rd_en        <= issue;
      wrap         <= issue & addr_wrap;
      sample_valid <= capture;

      if (issue) begin
        rd_addr <= addr;
        addr    <= addr_nxt;
      end else if (state == ST_IDLE) begin
        addr <= '0;
      end

      if (capture) begin
        sample_out <= rd_data;
      end

      // Only one locked-out tick is remembered; it is dropped on leaving WAIT.
      if ((state != ST_WAIT) || issue || !run) begin
        pending <= 1'b0;
      end else if (tick && mem_lock) begin
        pending <= 1'b1;
      end

      if (tick && ((state == ST_FETCH) || pending)) begin
        overrun <= 1'b1;
      end

      if (cfg_load) begin
        step_shd  <= cfg_step;
        range_shd <= cfg_range;
      end

      // A load landing on the same edge as the wrap takes effect right away.
      if (cfg_apply) begin
        step_act  <= cfg_load ? cfg_step  : step_shd;
        range_act <= cfg_load ? cfg_range : range_shd;
      end
    end
  end

`ifdef WAVE_SEQ_ONESHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_seen    <= 1'b0;
      oneshot_done <= 1'b0;
    end else begin
      if (issue) begin
        wrap_seen <= addr_wrap;
      end
      if (!run) begin
        oneshot_done <= 1'b0;
      end else if (capture && stop_now) begin
        oneshot_done <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer
// Scoreboard bench for wave_sequencer. Expected reads are queued when ticks
// are driven; a negedge monitor pops them on rd_en and queues the expected
// sample, popped again on sample_valid. Honours WAVE_SEQ_ONESHOT_EN.
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        tick = 1'b0;
  logic        mem_lock = 1'b0;
  logic        cfg_load = 1'b0;
  logic [11:0] cfg_step = '0;
  logic [11:0] cfg_range = '0;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        wrap;
  logic        overrun;
`ifdef WAVE_SEQ_ONESHOT_EN
  logic        oneshot = 1'b0;
`endif

  always #5 clk = ~clk;

  wave_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .tick        (tick),
    .mem_lock    (mem_lock),
`ifdef WAVE_SEQ_ONESHOT_EN
    .oneshot     (oneshot),
`endif
    .cfg_load    (cfg_load),
    .cfg_step    (cfg_step),
    .cfg_range   (cfg_range),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .wrap        (wrap),
    .overrun     (overrun)
  );

  typedef struct {
    logic [11:0] addr;
    logic        wrp;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } sm_exp_t;

  rd_exp_t rd_q[$];
  sm_exp_t sm_q[$];
  rd_exp_t mon_e;
  sm_exp_t mon_s;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic lock_prev = 1'b0;

  // Behavioural model of playback state.
  int m_addr, m_step, m_range, m_sh_step, m_sh_range;
  bit m_pend;

  function automatic logic [15:0] ram_word(input logic [11:0] a);
    logic [15:0] w;
    w = {4'h0, a} * 16'd263;
    return w ^ 16'h5A00;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    lock_prev <= mem_lock;
    if (rd_en) rd_data <= ram_word(rd_addr);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (rd_en === 1'b1) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got read addr=%0d at cycle %0d, required no read", rd_addr, cyc);
        end else begin
          mon_e = rd_q.pop_front();
          if (rd_addr !== mon_e.addr || wrap !== mon_e.wrp || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL rd_check: got addr=%0d wrap=%b cycle=%0d, required addr=%0d wrap=%b cycle=%0d",
                     rd_addr, wrap, cyc, mon_e.addr, mon_e.wrp, mon_e.cyc);
          end
          mon_s.data = ram_word(mon_e.addr);
          mon_s.cyc  = mon_e.cyc + 2;
          sm_q.push_back(mon_s);
        end
        n_cmp++;
        if (lock_prev !== 1'b0) begin
          n_err++;
          $display("FAIL rd_after_lock: got rd_en=1 after locked cycle, required 0");
        end
      end else if (wrap !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wrap_alone: got wrap=%b without rd_en, required 0", wrap);
      end
      if (sample_valid === 1'b1) begin
        n_cmp++;
        if (sm_q.size() == 0) begin
          n_err++;
          $display("FAIL sample_unexpected: got sample %h at cycle %0d, required none", sample_out, cyc);
        end else begin
          mon_s = sm_q.pop_front();
          if (sample_out !== mon_s.data || cyc != mon_s.cyc) begin
            n_err++;
            $display("FAIL sample_check: got %h at cycle %0d, required %h at cycle %0d",
                     sample_out, cyc, mon_s.data, mon_s.cyc);
          end
        end
      end
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; tick = 1'b0; mem_lock = 1'b0;
    cfg_load = 1'b0; cfg_step = '0; cfg_range = '0;
`ifdef WAVE_SEQ_ONESHOT_EN
    oneshot = 1'b0;
`endif
    repeat (2) step_cycle();
    rd_q.delete();
    sm_q.delete();
    reset = 1'b0;
    m_addr = 0; m_step = 1; m_range = 4095;
    m_sh_step = 1; m_sh_range = 4095; m_pend = 0;
    step_cycle();
  endtask

  // Configure while stopped (applies at once), then arm playback.
  task automatic set_cfg(input int stp, input int rng);
    cfg_step = 12'(stp); cfg_range = 12'(rng); cfg_load = 1'b1;
    step_cycle();
    cfg_load = 1'b0;
    m_step = stp; m_range = rng; m_sh_step = stp; m_sh_range = rng;
    run = 1'b1;
    repeat (2) step_cycle();
  endtask

  task automatic push_read(input int at_cyc);
    rd_exp_t e;
    int n;
    logic w;
    n = m_addr + m_step;
    w = 1'b0;
    if (n > m_range) begin
      n = n - (m_range + 1);
      w = 1'b1;
      if (n > m_range) n = 0;
    end
    e.addr = 12'(m_addr);
    e.wrp  = w;
    e.cyc  = at_cyc;
    rd_q.push_back(e);
    if (w && m_pend) begin
      m_step = m_sh_step; m_range = m_sh_range; m_pend = 0;
    end
    m_addr = n;
  endtask

  task automatic send_tick(input int gap);
    push_read(cyc + 1);
    tick = 1'b1;
    step_cycle();
    tick = 1'b0;
    repeat (gap - 1) step_cycle();
  endtask

  task automatic wait_drain(output int left);
    int k = 0;
    while ((rd_q.size() != 0 || sm_q.size() != 0) && k < 20) begin
      step_cycle();
      k++;
    end
    left = rd_q.size() + sm_q.size();
  endtask

  task automatic test_reset();
    int left;
    do_reset();
    n_cmp += 6;
    if (rd_en !== 1'b0)        begin n_err++; $display("FAIL reset_rd_en: got %b, required 0", rd_en); end
    if (rd_addr !== 12'd0)     begin n_err++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
    if (sample_out !== 16'd0)  begin n_err++; $display("FAIL reset_sample_out: got %h, required 0", sample_out); end
    if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_sample_valid: got %b, required 0", sample_valid); end
    if (wrap !== 1'b0)         begin n_err++; $display("FAIL reset_wrap: got %b, required 0", wrap); end
    if (overrun !== 1'b0)      begin n_err++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    // Default step 1 / full range without any cfg_load.
    run = 1'b1;
    repeat (2) step_cycle();
    for (int i = 0; i < 3; i++) send_tick(4);
    wait_drain(left);
    n_cmp++;
    if (left != 0) begin n_err++; $display("FAIL default_drain: got %0d outstanding, required 0", left); end
  endtask

  task automatic test_playback(input string tag, input int stp, input int rng, input int nt);
    int left;
    do_reset();
    set_cfg(stp, rng);
    for (int i = 0; i < nt; i++) send_tick(4);
    wait_drain(left);
    n_cmp += 2;
    if (left != 0) begin n_err++; $display("FAIL %s_drain: got %0d outstanding, required 0", tag, left); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL %s_overrun: got %b, required 0", tag, overrun); end
  endtask

  task automatic test_mem_lock();
    int left;
    int bad = 0;
    do_reset();
    set_cfg(1, 3);
    send_tick(4);
    wait_drain(left);
    mem_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick = (i == 4);
      step_cycle();
      if (rd_en !== 1'b0) bad++;
    end
    tick = 1'b0;
    push_read(cyc + 1);
    mem_lock = 1'b0;
    step_cycle();
    wait_drain(left);
    n_cmp += 3;
    if (bad != 0) begin n_err++; $display("FAIL lock_read: got %0d reads while locked, required 0", bad); end
    if (left != 0) begin n_err++; $display("FAIL lock_drain: got %0d outstanding, required 0", left); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL lock_overrun: got %b, required 0", overrun); end
  endtask

  task automatic test_back_to_back();
    int left;
    do_reset();
    set_cfg(1, 3);
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_pre_overrun: got %b, required 0", overrun); end
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 0) push_read(cyc + 1);
      tick = 1'b1;
      step_cycle();
    end
    tick = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b, required 1", overrun); end
    repeat (8) step_cycle();
    wait_drain(left);
    n_cmp += 2;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_sticky: got %b, required 1", overrun); end
    if (left != 0) begin n_err++; $display("FAIL b2b_drain: got %0d outstanding, required 0", left); end
    do_reset();
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_cleared: got %b, required 0", overrun); end
  endtask

  task automatic test_cfg_midplay();
    int left;
    do_reset();
    set_cfg(1, 3);
    send_tick(4);
    send_tick(4);
    cfg_step = 12'd2; cfg_range = 12'd15; cfg_load = 1'b1;
    step_cycle();
    cfg_load = 1'b0;
    m_sh_step = 2; m_sh_range = 15; m_pend = 1;
    for (int i = 0; i < 5; i++) send_tick(4);
    wait_drain(left);
    n_cmp++;
    if (left != 0) begin n_err++; $display("FAIL cfg_drain: got %0d outstanding, required 0", left); end
  endtask

  task automatic test_run_drop();
    int left;
    do_reset();
    set_cfg(1, 3);
    send_tick(4);
    send_tick(4);
    push_read(cyc + 1);
    tick = 1'b1;
    step_cycle();
    tick = 1'b0;
    run = 1'b0;
    m_addr = 0;
    wait_drain(left);
    n_cmp++;
    if (left != 0) begin n_err++; $display("FAIL rundrop_drain: got %0d outstanding, required 0", left); end
    repeat (2) step_cycle();
    run = 1'b1;
    repeat (2) step_cycle();
    send_tick(4);
    wait_drain(left);
    n_cmp++;
    if (left != 0) begin n_err++; $display("FAIL rundrop_restart: got %0d outstanding, required 0", left); end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    do_reset();
    set_cfg(1, 3);
    push_read(cyc + 1);
    tick = 1'b1;
    step_cycle();
    tick = 1'b0;
    step_cycle();
    reset = 1'b1;
    rd_q.delete();
    sm_q.delete();
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      if (sample_valid !== 1'b0) seen++;
    end
    reset = 1'b0;
    step_cycle();
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL abort_valid: got %0d sample_valid pulses, required 0", seen); end
  endtask

`ifdef WAVE_SEQ_ONESHOT_EN
  task automatic test_oneshot();
    int left;
    do_reset();
    oneshot = 1'b1;
    set_cfg(1, 1);
    send_tick(4);
    send_tick(4);
    send_tick(4);
    rd_q.delete();
    m_addr = 0;
    wait_drain(left);
    run = 1'b0;
    repeat (2) step_cycle();
    run = 1'b1;
    repeat (2) step_cycle();
    send_tick(4);
    wait_drain(left);
    oneshot = 1'b0;
    n_cmp++;
    if (left != 0) begin n_err++; $display("FAIL oneshot_drain: got %0d outstanding, required 0", left); end
  endtask
`endif

  initial begin
    test_reset();
    test_playback("s1r3", 1, 3, 6);
    test_playback("s5r7", 5, 7, 6);
    test_playback("s20r7", 20, 7, 4);
    test_playback("s3r0", 3, 0, 3);
    test_playback("s0r7", 0, 7, 3);
    test_mem_lock();
    test_back_to_back();
    test_cfg_midplay();
    test_run_drop();
    test_reset_abort();
`ifdef WAVE_SEQ_ONESHOT_EN
    test_oneshot();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
